// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: multi-cycle fetch/decode/execute control unit with embedded ALU
// Ports: clk, rst (async, active-low); instr in from instruction memory, pc out to it;
// register bank: addR1/addR2 read addresses, dadoR1/dadoR2 registered read data,
// wrEn/addWr/dadoWr write port; zero flag of last ALU op; halted once HLT decoded.
module unidade_controle_multiciclo #(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           instr,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  wrEn,
  output logic [2:0]            addR1,
  output logic [2:0]            addR2,
  output logic [2:0]            addWr,
  output logic [DATA_WIDTH-1:0] dadoWr,
  input  logic [DATA_WIDTH-1:0] dadoR1,
  input  logic [DATA_WIDTH-1:0] dadoR2,
  output logic                  zero,
  output logic                  halted
);
  typedef enum logic [2:0] {FETCH, DECODE, READ, EXEC, WRITE, HALT} state_t;
  state_t state, next;
  logic [15:0] ir;
  logic [3:0] op;
  logic is_alu, writes;
  logic [DATA_WIDTH-1:0] alu, r1;
  assign op = ir[15:12];
  assign is_alu = op inside {[4'd1:4'd5]};
  assign writes = is_alu || op == 4'd6 || op == 4'd7;
  // Read addresses come straight from ir: valid from READ on and held until the next DECODE.
  assign addR1 = op == 4'd9 ? ir[11:9] : ir[8:6];
  assign addR2 = ir[5:3];
  assign halted = state == HALT;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= FETCH;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      FETCH:   next = DECODE;
      DECODE:  next = instr[15:12] == 4'hF ? HALT : READ;
      READ:    next = EXEC;
      EXEC:    next = WRITE;
      WRITE:   next = FETCH;
      default: next = HALT;
    endcase
  end
  always_comb begin
    alu = op == 4'd1 ? dadoR1 + dadoR2 :
          op == 4'd2 ? dadoR1 - dadoR2 :
          op == 4'd3 ? dadoR1 & dadoR2 :
          op == 4'd4 ? dadoR1 | dadoR2 :
          op == 4'd5 ? dadoR1 ^ dadoR2 :
          op == 4'd6 ? DATA_WIDTH'(ir[7:0]) : dadoR1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc     <= '0;
      ir     <= '0;
      wrEn   <= 1'b0;
      addWr  <= '0;
      dadoWr <= '0;
      zero   <= 1'b0;
      r1     <= '0;
    end else begin
      if (state == DECODE) ir <= instr;
      // Write port is loaded at the end of EXEC so wrEn is high for exactly the WRITE cycle.
      if (state == EXEC) begin
        r1 <= dadoR1;
        if (is_alu) zero <= alu == '0;
        if (writes) begin
          wrEn   <= 1'b1;
          addWr  <= ir[11:9];
          dadoWr <= alu;
        end
      end
      if (state == WRITE) begin
        wrEn <= 1'b0;
        pc   <= (op == 4'd8 || (op == 4'd9 && r1 == '0)) ? PC_WIDTH'(ir[7:0]) : pc + PC_WIDTH'(1);
      end
    end
endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// tb_unidade_controle_multiciclo: table vectors, corner sequences and random ISA-model check
module tb_unidade_controle_multiciclo;
  logic clk = 1'b0, rst = 1'b0, bank_rst = 1'b1;
  logic [15:0] instr;
  logic [7:0] pc, dadoWr, dadoR1, dadoR2;
  logic wrEn, zero, halted;
  logic [2:0] addR1, addR2, addWr;
  logic [15:0] imem [256];
  logic [7:0] bank [8];
  int tests = 0, fails = 0;

  unidade_controle_multiciclo #(.PC_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc), .wrEn(wrEn),
    .addR1(addR1), .addR2(addR2), .addWr(addWr), .dadoWr(dadoWr),
    .dadoR1(dadoR1), .dadoR2(dadoR2), .zero(zero), .halted(halted)
  );

  always #5 clk = ~clk;

  // Environment: synchronous instruction memory and register bank with registered reads.
  always @(posedge clk) begin
    instr <= imem[pc];
    if (bank_rst) for (int i = 0; i < 8; i++) bank[i] <= 8'hA0 + 8'(i);
    else if (wrEn) bank[addWr] <= dadoWr;
    dadoR1 <= bank[addR1];
    dadoR2 <= bank[addR2];
  end

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  pc;
    logic        we;
    logic [2:0]  wa;
    logic [7:0]  wd;
    logic        z;
    logic [7:0]  npc;
  } vec_t;
  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bank_rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bank_rst = 1'b0;
    rst = 1'b1;
  endtask

  // Runs one 5-cycle instruction starting in FETCH; ends sampled in the next FETCH.
  task automatic run_instr(output int wcnt, output int wcyc, output logic [2:0] wa, output logic [7:0] wd);
    wcnt = 0; wcyc = -1; wa = '0; wd = '0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (wrEn === 1'b1) begin
        wcnt++; wcyc = k; wa = addWr; wd = dadoWr;
      end else if (wrEn !== 1'b0) wcnt += 100;
    end
  endtask

  initial begin
    int wcnt, wcyc;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [7:0] rr [8];
    logic [7:0] rpc, a, b, d, npc;
    logic rz, we;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    vt[0]  = '{16'h0000, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 8'h01};
    vt[1]  = '{16'h1650, 8'h01, 1'b1, 3'd3, 8'h43, 1'b0, 8'h02};
    vt[2]  = '{16'h2968, 8'h02, 1'b1, 3'd4, 8'h00, 1'b1, 8'h03};
    vt[3]  = '{16'h3050, 8'h03, 1'b1, 3'd0, 8'hA0, 1'b0, 8'h04};
    vt[4]  = '{16'h607F, 8'h04, 1'b1, 3'd0, 8'h7F, 1'b0, 8'h05};
    vt[5]  = '{16'h7200, 8'h05, 1'b1, 3'd1, 8'h7F, 1'b0, 8'h06};
    vt[6]  = '{16'h8010, 8'h06, 1'b0, 3'd0, 8'h00, 1'b0, 8'h10};
    vt[7]  = '{16'h9420, 8'h10, 1'b0, 3'd0, 8'h00, 1'b0, 8'h11};
    vt[8]  = '{16'h6400, 8'h11, 1'b1, 3'd2, 8'h00, 1'b0, 8'h12};
    vt[9]  = '{16'h9420, 8'h12, 1'b0, 3'd0, 8'h00, 1'b0, 8'h20};
    vt[10] = '{16'h4A88, 8'h20, 1'b1, 3'd5, 8'h7F, 1'b0, 8'h21};
    vt[11] = '{16'h5C48, 8'h21, 1'b1, 3'd6, 8'h00, 1'b1, 8'h22};
    vt[12] = '{16'hA000, 8'h22, 1'b0, 3'd0, 8'h00, 1'b1, 8'h23};
    for (int i = 0; i < 13; i++) imem[vt[i].pc] = vt[i].ins;
    imem[8'h23] = 16'hF000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {4'd0, pc, wrEn, addR1, addR2, addWr, dadoWr, zero, halted}, 32'd0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      chk($sformatf("v%0d_pc", i), pc, vt[i].pc);
      run_instr(wcnt, wcyc, wa, wd);
      chk($sformatf("v%0d_wecnt", i), wcnt, vt[i].we);
      if (vt[i].we) begin
        chk($sformatf("v%0d_wecyc", i), wcyc, 4);
        chk($sformatf("v%0d_addwr", i), wa, vt[i].wa);
        chk($sformatf("v%0d_dadowr", i), wd, vt[i].wd);
      end
      chk($sformatf("v%0d_zero", i), zero, vt[i].z);
      chk($sformatf("v%0d_npc", i), pc, vt[i].npc);
    end

    // HLT: halted rises the cycle after DECODE, then pc and wrEn frozen.
    @(posedge clk); @(negedge clk);
    chk("hlt_decode_halted", halted, 1'b0);
    for (int k = 0; k < 22; k++) begin
      @(posedge clk); @(negedge clk);
      chk("hlt_frozen", {halted, wrEn, pc}, {1'b1, 1'b0, 8'h23});
    end

    // Reset asserted during EXEC of ADD R7,R1,R2: no write, pc cleared immediately.
    imem[0] = 16'h0000;
    imem[1] = 16'h1E50;
    do_reset();
    run_instr(wcnt, wcyc, wa, wd);
    chk("rexec_pc_before", pc, 8'h01);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    #1;
    chk("rexec_async", {pc, wrEn, halted, addR1}, 13'd0);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("rexec_wren", wrEn, 1'b0);
    end
    chk("rexec_r7_kept", bank[7], 8'hA7);

    // Random programs against an instruction-level reference model.
    for (int i = 0; i < 256; i++) imem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    imem[0] = 16'h80FF;
    imem[255] = 16'h0000;
    do_reset();
    for (int n = 0; n < 8; n++) rr[n] = 8'hA0 + 8'(n);
    rpc = 8'h00;
    rz = 1'b0;
    for (int n = 0; n < 200; n++) begin
      logic [15:0] ins;
      ins = imem[rpc];
      a = rr[ins[8:6]];
      b = rr[ins[5:3]];
      we = 1'b0;
      d = 8'h00;
      npc = rpc + 8'd1;
      case (ins[15:12])
        4'd1: begin d = a + b; we = 1'b1; rz = d == 8'h00; end
        4'd2: begin d = a - b; we = 1'b1; rz = d == 8'h00; end
        4'd3: begin d = a & b; we = 1'b1; rz = d == 8'h00; end
        4'd4: begin d = a | b; we = 1'b1; rz = d == 8'h00; end
        4'd5: begin d = a ^ b; we = 1'b1; rz = d == 8'h00; end
        4'd6: begin d = ins[7:0]; we = 1'b1; end
        4'd7: begin d = a; we = 1'b1; end
        4'd8: npc = ins[7:0];
        4'd9: npc = rr[ins[11:9]] == 8'h00 ? ins[7:0] : rpc + 8'd1;
        default: ;
      endcase
      if (we) rr[ins[11:9]] = d;
      chk($sformatf("r%0d_pc", n), pc, rpc);
      run_instr(wcnt, wcyc, wa, wd);
      chk($sformatf("r%0d_wecnt", n), wcnt, we);
      if (we) chk($sformatf("r%0d_write", n), {wcyc[7:0], 5'd0, wa, wd}, {8'd4, 5'd0, ins[11:9], d});
      chk($sformatf("r%0d_zero", n), zero, rz);
      rpc = npc;
    end
    chk("rand_final_pc", pc, rpc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
